// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the framed UART receiver:
//   - rx_state_t      : receiver FSM state encoding
//   - PARITY_*        : PARITY_MODE encodings (none / even / odd)
//   - rx_params_legal : elaboration-time legality check of the parameter set
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  function automatic bit rx_params_legal(
    input int unsigned oversample,
    input int unsigned n_data_bits,
    input int unsigned parity_mode,
    input int unsigned n_stop_bits,
    input int unsigned maj_start,
    input int unsigned maj_end,
    input int unsigned sync_stages
  );
    return (oversample >= 8) && (oversample <= 32) &&
           (n_data_bits >= 5) && (n_data_bits <= 9) &&
           (parity_mode <= PARITY_ODD) &&
           (n_stop_bits >= 1) && (n_stop_bits <= 2) &&
           (maj_start <= maj_end) && (maj_end < oversample) &&
           (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// uart_rx_framed_if
//   Output word handshake of the framed UART receiver.
//   master : receiver side (drives word, valid, error flags, overrun)
//   slave  : consumer side (drives i_data_ready)
//   o_data        : received word, LSB first on the line
//   o_data_valid  : held word valid
//   i_data_ready  : consumer accepts the held word
//   o_parity_err  : parity error of the held word (qualified by valid)
//   o_frame_err   : framing error of the held word (qualified by valid)
//   o_overrun     : one-cycle pulse when a completed frame is dropped
interface uart_rx_framed_if #(
  parameter int unsigned N_DATA_BITS = 8
) ();
  logic [N_DATA_BITS-1:0] o_data;
  logic                   o_data_valid;
  logic                   i_data_ready;
  logic                   o_parity_err;
  logic                   o_frame_err;
  logic                   o_overrun;

  modport master (
    output o_data, o_data_valid, o_parity_err, o_frame_err, o_overrun,
    input  i_data_ready
  );

  modport slave (
    input  o_data, o_data_valid, o_parity_err, o_frame_err, o_overrun,
    output i_data_ready
  );
endinterface

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler
//   Per-bit sample counter and majority vote for the UART receiver.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_en           : oversample tick; all state holds when low
//   i_line         : synchronized serial line
//   i_start        : start-edge seen this tick; this tick is sample 0
//   i_run          : receiver is inside a frame (count and vote)
//   o_bit_done     : strobe on the tick that completes a bit (last sample)
//   o_bit_val      : resolved bit value, valid with o_bit_done
module uart_bit_sampler #(
  parameter int unsigned OVERSAMPLE         = 16,
  parameter int unsigned MAJORITY_START_IDX = 6,
  parameter int unsigned MAJORITY_END_IDX   = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_line,
  input  logic i_start,
  input  logic i_run,
  output logic o_bit_done,
  output logic o_bit_val
);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned WIN   = MAJORITY_END_IDX - MAJORITY_START_IDX + 1;
  localparam int unsigned MAJ_W = $clog2(WIN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(MAJORITY_START_IDX);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(MAJORITY_END_IDX);
  localparam logic [MAJ_W:0]   WIN_V    = (MAJ_W + 1)'(WIN);

  logic [CNT_W-1:0] cnt;
  logic [MAJ_W-1:0] maj;
  logic [MAJ_W-1:0] maj_next;
  logic             in_win;

  always_comb begin
    in_win     = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    maj_next   = maj + MAJ_W'(in_win & i_line);
    // Twice the count beats the window width exactly when count > width/2.
    o_bit_val  = {maj_next, 1'b0} > WIN_V;
    o_bit_done = i_en & i_run & (cnt == CNT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
      maj <= '0;
    end else if (i_en) begin
      if (i_start) begin
        // The start tick is sample 0; the line is low so it adds no vote.
        cnt <= CNT_ONE;
        maj <= '0;
      end else if (i_run) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          maj <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
          maj <= maj_next;
        end
      end
    end
  end
endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   Oversampling UART receiver with parity, stop-bit checking, break
//   handling and a one-word output register with valid/ready handshake.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_en           : oversample tick (OVERSAMPLE ticks per bit)
//   i_data         : asynchronous serial line, idle high
//   o_busy         : FSM is not idle
//   rx_if          : word / valid / ready / error flags / overrun
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE         = 16,
  parameter int unsigned N_DATA_BITS        = 8,
  parameter int unsigned PARITY_MODE        = 0,
  parameter int unsigned N_STOP_BITS        = 1,
  parameter int unsigned MAJORITY_START_IDX = 6,
  parameter int unsigned MAJORITY_END_IDX   = 10,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_data,
  output logic o_busy,
  uart_rx_framed_if.master rx_if
);
  if (!rx_params_legal(OVERSAMPLE, N_DATA_BITS, PARITY_MODE, N_STOP_BITS,
                       MAJORITY_START_IDX, MAJORITY_END_IDX, SYNC_STAGES)) begin : g_bad_params
    $error("uart_rx_framed: illegal parameter set");
  end

  localparam int unsigned      IDX_W     = $clog2(N_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             STOP_LAST = 1'(N_STOP_BITS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  rx_state_t              state;
  logic [IDX_W-1:0]       bit_idx;
  logic                   stop_idx;
  logic [N_DATA_BITS-1:0] shreg;
  logic                   par_err_r;
  logic                   frm_err_r;
  logic                   bit_done;
  logic                   bit_val;
  logic                   start_seen;
  logic                   run;
  logic                   frm_err_final;
  logic                   frame_done;
  logic                   xfer;

  always_ff @(posedge i_clk) begin
    if (i_reset) sync <= '1;
    else         sync <= {sync[SYNC_STAGES-2:0], i_data};
  end

  always_comb begin
    line          = sync[SYNC_STAGES-1];
    start_seen    = (state == ST_IDLE) & ~line;
    run           = (state == ST_START) | (state == ST_DATA) |
                    (state == ST_PARITY) | (state == ST_STOP);
    frm_err_final = frm_err_r | ~bit_val;
    frame_done    = bit_done & (state == ST_STOP) & (stop_idx == STOP_LAST);
    xfer          = rx_if.o_data_valid & rx_if.i_data_ready;
    o_busy        = (state != ST_IDLE);
  end

  uart_bit_sampler #(
    .OVERSAMPLE        (OVERSAMPLE),
    .MAJORITY_START_IDX(MAJORITY_START_IDX),
    .MAJORITY_END_IDX  (MAJORITY_END_IDX)
  ) u_sampler (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_line    (line),
    .i_start   (start_seen),
    .i_run     (run),
    .o_bit_done(bit_done),
    .o_bit_val (bit_val)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else if (i_en) begin
      case (state)
        ST_IDLE: if (!line) begin
          state     <= ST_START;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          par_err_r <= 1'b0;
          frm_err_r <= 1'b0;
        end
        ST_START: if (bit_done) state <= bit_val ? ST_IDLE : ST_DATA;
        ST_DATA: if (bit_done) begin
          shreg <= {bit_val, shreg[N_DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST)
            state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_idx <= bit_idx + IDX_ONE;
        end
        ST_PARITY: if (bit_done) begin
          par_err_r <= ((^shreg) ^ bit_val) != (PARITY_MODE == PARITY_ODD);
          state     <= ST_STOP;
        end
        ST_STOP: if (bit_done) begin
          frm_err_r <= frm_err_final;
          if (stop_idx == STOP_LAST)
            state <= frm_err_final ? ST_WAIT_HIGH : ST_IDLE;
          else
            stop_idx <= 1'b1;
        end
        ST_WAIT_HIGH: if (line) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a completed frame loads only into an empty slot or one
  // being drained this same cycle; otherwise it is dropped with a pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_if.o_data       <= '0;
      rx_if.o_data_valid <= 1'b0;
      rx_if.o_parity_err <= 1'b0;
      rx_if.o_frame_err  <= 1'b0;
      rx_if.o_overrun    <= 1'b0;
    end else begin
      rx_if.o_overrun <= 1'b0;
      if (frame_done && (!rx_if.o_data_valid || xfer)) begin
        rx_if.o_data       <= shreg;
        rx_if.o_parity_err <= par_err_r;
        rx_if.o_frame_err  <= frm_err_final;
        rx_if.o_data_valid <= 1'b1;
      end else begin
        if (frame_done) rx_if.o_overrun <= 1'b1;
        if (xfer)       rx_if.o_data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed
//   Self-checking bench for uart_rx_framed (16x oversample, 8 data bits,
//   even parity, 1 stop bit). Ticks on i_en arrive with random gaps.
module tb_uart_rx_framed;
  import uart_pkg::*;

  localparam int unsigned OS = 16;
  localparam int unsigned NB = 8;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_en;
  logic i_data;
  logic o_busy;

  uart_rx_framed_if #(.N_DATA_BITS(NB)) rx_if ();

  uart_rx_framed #(
    .OVERSAMPLE        (OS),
    .N_DATA_BITS       (NB),
    .PARITY_MODE       (PARITY_EVEN),
    .N_STOP_BITS       (1),
    .MAJORITY_START_IDX(6),
    .MAJORITY_END_IDX  (10),
    .SYNC_STAGES       (2)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (i_en),
    .i_data (i_data),
    .o_busy (o_busy),
    .rx_if  (rx_if)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: words accepted by the consumer, valid-high cycles, overruns.
  logic [9:0] obs [256];
  int obs_n        = 0;
  int valid_cycles = 0;
  int overrun_cnt  = 0;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (rx_if.o_data_valid) valid_cycles++;
      if (rx_if.o_overrun) overrun_cnt++;
      if (rx_if.o_data_valid && rx_if.i_data_ready && obs_n < 256) begin
        obs[obs_n] = {rx_if.o_frame_err, rx_if.o_parity_err, rx_if.o_data};
        obs_n++;
      end
    end
  end

  // Reference: {frame_err, parity_err, data} from the bits put on the line.
  function automatic logic [9:0] model(input logic [7:0] d, input logic pbit, input logic stop);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    if (pbit) ones++;
    return {~stop, ((ones % 2) != 0), d};
  endfunction

  function automatic logic even_pbit(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2) != 0;
  endfunction

  task automatic tick(input logic v);
    i_data = v;
    i_en   = 1'b1;
    @(posedge i_clk); #1;
    i_en = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_bit(input logic v);
    repeat (OS) tick(v);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(stop);
    repeat (6) tick(1'b1);
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_en = 1'b0; i_data = 1'b1; rx_if.i_data_ready = 1'b1;
    repeat (3) begin @(posedge i_clk); #1; end
    i_en = 1'b1; i_data = 1'b0;
    repeat (4) begin @(posedge i_clk); #1; end
    i_en = 1'b0; i_data = 1'b1;
    n_checks++;
    if ({rx_if.o_data, rx_if.o_data_valid, rx_if.o_parity_err, rx_if.o_frame_err,
         rx_if.o_overrun, o_busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_if.o_data, rx_if.o_data_valid, rx_if.o_parity_err, rx_if.o_frame_err,
               rx_if.o_overrun, o_busy);
    end
    repeat (3) begin @(posedge i_clk); #1; end
    i_reset = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_good_frames;
    int b, v;
    logic [7:0] d [2];
    logic       p [2];
    d[0] = 8'hA5; p[0] = 1'b0;
    d[1] = 8'h3C; p[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b = obs_n; v = valid_cycles;
      send_frame(d[k], p[k], 1'b1);
      n_checks++;
      if (obs_n - b != 1 || valid_cycles - v != 1) begin
        n_fail++;
        $display("FAIL good_frame_count[%0d]: got words=%0d valid_cycles=%0d, expected 1/1",
                 k, obs_n - b, valid_cycles - v);
      end
      n_checks++;
      if (obs[b] !== model(d[k], p[k], 1'b1)) begin
        n_fail++;
        $display("FAIL good_frame_word[%0d]: got %h expected %h", k, obs[b], model(d[k], p[k], 1'b1));
      end
    end
  endtask

  task automatic test_glitch;
    int b, v;
    b = obs_n; v = valid_cycles;
    repeat (3) tick(1'b0);
    repeat (24) tick(1'b1);
    n_checks++;
    if (valid_cycles - v != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_ignored: got valid_cycles=%0d busy=%b, expected 0/0", valid_cycles - v, o_busy);
    end
    send_frame(8'h55, 1'b0, 1'b1);
    n_checks++;
    if (obs_n - b != 1 || obs[b] !== model(8'h55, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL glitch_next_frame: got n=%0d word=%h expected 1 word %h",
               obs_n - b, obs[b], model(8'h55, 1'b0, 1'b1));
    end
  endtask

  task automatic test_frame_err;
    int b, v;
    b = obs_n; v = valid_cycles;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 4);
    send_bit(1'b0);
    repeat (41 * OS) tick(1'b0);
    n_checks++;
    if (obs_n - b != 1 || valid_cycles - v != 1 || obs[b] !== model(8'h0F, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL frame_err_word: got n=%0d valid_cycles=%0d word=%h expected 1/1 %h",
               obs_n - b, valid_cycles - v, obs[b], model(8'h0F, 1'b0, 1'b0));
    end
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL break_wait_busy: got %b expected 1", o_busy);
    end
    repeat (6) tick(1'b1);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_release_idle: got %b expected 0", o_busy);
    end
    b = obs_n;
    send_frame(8'h5A, 1'b0, 1'b1);
    n_checks++;
    if (obs_n - b != 1 || obs[b] !== model(8'h5A, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL after_break_frame: got n=%0d word=%h expected 1 word %h",
               obs_n - b, obs[b], model(8'h5A, 1'b0, 1'b1));
    end
  endtask

  task automatic test_overrun;
    int b, o;
    b = obs_n; o = overrun_cnt;
    rx_if.i_data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    n_checks++;
    if (overrun_cnt - o != 1) begin
      n_fail++;
      $display("FAIL overrun_pulses: got %0d expected 1", overrun_cnt - o);
    end
    n_checks++;
    if (rx_if.o_data_valid !== 1'b1 || rx_if.o_data !== 8'h11 || obs_n - b != 0) begin
      n_fail++;
      $display("FAIL overrun_hold: got v=%b data=%h accepted=%0d expected 1 11 0",
               rx_if.o_data_valid, rx_if.o_data, obs_n - b);
    end
    rx_if.i_data_ready = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    n_checks++;
    if (obs_n - b != 1 || obs[b] !== model(8'h11, 1'b0, 1'b1) || rx_if.o_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_drain: got n=%0d word=%h v=%b expected 1 %h 0",
               obs_n - b, obs[b], rx_if.o_data_valid, model(8'h11, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset_mid_frame;
    int b;
    logic [7:0] d;
    d = 8'h99;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    repeat (8) tick(d[3]);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame_busy: got %b expected 1", o_busy);
    end
    i_data = 1'b1; i_en = 1'b1; i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_en = 1'b0;
    n_checks++;
    if ({rx_if.o_data, rx_if.o_data_valid, rx_if.o_parity_err, rx_if.o_frame_err,
         rx_if.o_overrun, o_busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_if.o_data, rx_if.o_data_valid, rx_if.o_parity_err, rx_if.o_frame_err,
               rx_if.o_overrun, o_busy);
    end
    repeat (20) tick(1'b1);
    b = obs_n;
    send_frame(8'h66, 1'b0, 1'b1);
    n_checks++;
    if (obs_n - b != 1 || obs[b] !== model(8'h66, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL post_reset_frame: got n=%0d word=%h expected 1 word %h",
               obs_n - b, obs[b], model(8'h66, 1'b0, 1'b1));
    end
  endtask

  task automatic test_random_frames;
    logic [9:0] exp_q [$];
    int b, v;
    logic [7:0] d;
    logic p, s;
    b = obs_n; v = valid_cycles;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~even_pbit(d) : even_pbit(d);
      s = ($urandom_range(0, 5) != 0);
      exp_q.push_back(model(d, p, s));
      send_frame(d, p, s);
    end
    n_checks++;
    if (obs_n - b != 16 || valid_cycles - v != 16) begin
      n_fail++;
      $display("FAIL random_count: got words=%0d valid_cycles=%0d expected 16/16",
               obs_n - b, valid_cycles - v);
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (obs[b + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL random_word[%0d]: got %h expected %h", k, obs[b + k], exp_q[k]);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frames();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: i_en ticks per bit period, legal range 8..32.
REQ-002 SHALL have parameter N_DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter N_STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 SHALL have parameters MAJORITY_START_IDX, default 6, and MAJORITY_END_IDX, default 10: inclusive sample window within a bit.
REQ-006 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port i_en, input, 1 bit: oversample tick, one i_clk cycle wide.
REQ-010 SHALL have port i_data, input, 1 bit: asynchronous serial line, idle high.
REQ-011 SHALL have port i_data_ready, input, 1 bit: consumer accepts the held word.
REQ-012 SHALL have port o_data, output, N_DATA_BITS bits: received word, LSB first on the line.
REQ-013 SHALL have port o_data_valid, output, 1 bit: held word valid.
REQ-014 SHALL have ports o_parity_err and o_frame_err, output, 1 bit each: qualified by o_data_valid.
REQ-015 SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL pass i_data through SYNC_STAGES flops every i_clk cycle, independent of i_en; all decoding uses the synchronized line.
REQ-018 SHALL advance all bit-timing state (FSM, sample counter, bit index, majority count) only on cycles with i_en=1; on i_en=0 cycles it SHALL hold.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-020 SHALL, in IDLE, move to START on the first tick with the line low, and set the sample counter so that tick counts as sample 0.
REQ-021 SHALL keep a sample counter 0..OVERSAMPLE-1 per bit, count the high samples at indices MAJORITY_START_IDX..MAJORITY_END_IDX, and resolve the bit as 1 if that count exceeds half the window width, evaluated at counter OVERSAMPLE-1.
REQ-022 SHALL, in START, return to IDLE on a resolved start bit of 1 (false start), with no output and no flags; a resolved 0 SHALL move to DATA.
REQ-023 SHALL, in DATA, shift N_DATA_BITS resolved bits LSB first, then move to PARITY if PARITY_MODE is nonzero, else to STOP.
REQ-024 SHALL set the parity error when the XOR of the data bits and the received parity bit is not 0 for even parity, or not 1 for odd parity.
REQ-025 SHALL, in STOP, resolve N_STOP_BITS bits; any resolved stop bit of 0 SHALL set the frame error.
REQ-026 SHALL, after the final stop bit, go to IDLE if no frame error occurred, else to WAIT_HIGH; WAIT_HIGH SHALL go to IDLE on the first tick with the line high (break cannot retrigger).
REQ-027 SHALL, on the i_clk edge that resolves the final stop bit, load the word and both error flags into the output register with o_data_valid=1 if the register is empty or is being accepted that same cycle.
REQ-028 SHALL otherwise discard the new frame, keep the held word and flags, and pulse o_overrun for exactly one cycle.
REQ-029 SHALL treat o_data_valid & i_data_ready as a transfer, and clear o_data_valid on the next edge unless a simultaneous load applies; the handshake is not gated by i_en.
REQ-030 SHALL keep o_data, o_parity_err and o_frame_err stable while o_data_valid=1 and no transfer has occurred.

Reset
REQ-031 SHALL, on i_reset=1 at a clock edge, regardless of i_en or state (including mid-frame), set FSM=IDLE, counters=0, o_data=0, o_data_valid=0, error flags=0, o_overrun=0, o_busy=0, and synchronizer flops=1.
REQ-032 SHALL discard a partial frame on reset, and the first frame after reset SHALL decode correctly with no residual state.

Structure
REQ-033 SHALL place the FSM state enum, the PARITY_MODE encodings (NONE/EVEN/ODD) and a parameter-legality check function in the shared package uart_pkg.
REQ-034 SHALL instantiate one sub-module, uart_bit_sampler, containing the sample counter and majority vote and providing a per-bit resolved value and a bit-done strobe; the FSM and output register SHALL stay in uart_rx_framed.

Verification (OVERSAMPLE=16, N_DATA_BITS=8, PARITY_MODE=1, N_STOP_BITS=1, i_data_ready=1 unless stated)
REQ-035 SHALL cover: frame 0xA5 with parity bit 0 -> o_data=0xA5, o_parity_err=0, o_frame_err=0, o_data_valid for exactly 1 cycle.
REQ-036 SHALL cover: frame 0x3C with parity bit 1 -> o_data=0x3C, o_parity_err=1.
REQ-037 SHALL cover: 3-tick low glitch on an idle line -> no o_data_valid; a following 0x55 frame -> o_data=0x55.
REQ-038 SHALL cover: frame 0x0F with stop bit low, line held low 40 bit times -> o_frame_err=1, single o_data_valid, then no further frames until the line goes high.
REQ-039 SHALL cover: i_data_ready=0, frames 0x11 then 0x22 -> o_data stays 0x11, one o_overrun pulse at the 0x22 stop bit; ready=1 -> transfer of 0x11.
REQ-040 SHALL cover: i_reset pulsed mid-DATA of 0x99 -> all outputs 0 next cycle; next frame 0x66 -> o_data=0x66, no errors.
